// File: rtl/mrs_8_unshift.sv
// rtl/mrs_8_unshift.sv - sequential inverse of the masking rotating shifter
// Rebuilds the pre-shift word one bit position per clock and flags bits lost to zero fill.
module mrs_8_unshift #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_mask
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  localparam logic [1:0] MODE_ROR = 2'b00;
  localparam logic [1:0] MODE_ROL = 2'b01;
  localparam logic [1:0] MODE_SHR = 2'b10;
  localparam logic [1:0] MODE_SHL = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [1:0]       mode_q, mode_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          mask_d  = '1;
          mode_d  = in_mode;
          cnt_d   = in_sel;
          state_d = (in_sel == '0) ? DONE : STEP;
        end
      end

      STEP: begin
        // Each step undoes one position of the forward shift, in the opposite direction.
        cnt_d = cnt_q - SEL_W'(1);
        case (mode_q)
          MODE_ROR: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          MODE_ROL: data_d = {data_q[0], data_q[WIDTH-1:1]};
          MODE_SHR: begin
            data_d = data_q << 1;
            mask_d = mask_q << 1;
          end
          MODE_SHL: begin
            data_d = data_q >> 1;
            mask_d = mask_q >> 1;
          end
          default: data_d = data_q;
        endcase
        if (cnt_d == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_data = data_q;
  assign out_mask = mask_q;

endmodule

// File: tb/tb_mrs_8_unshift.sv
// tb/tb_mrs_8_unshift.sv - directed and loopback bench for mrs_8_unshift
module tb_mrs_8_unshift;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_mask;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mrs_8_unshift #(.WIDTH(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Forward shifter model (mrs_8) used to build loopback stimulus.
  function automatic logic [7:0] fwd(input logic [7:0] d, input int s, input logic [1:0] m);
    logic [7:0] r;
    case (m)
      2'b00:   r = (d >> s) | (d << (8 - s));
      2'b01:   r = (d << s) | (d >> (8 - s));
      2'b10:   r = d >> s;
      default: r = d << s;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] exp_mask(input int s, input logic [1:0] m);
    logic [7:0] ff;
    ff = 8'hFF;
    if (m == 2'b10) return ff << s;
    if (m == 2'b11) return ff >> s;
    return ff;
  endfunction

  task automatic run_job(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                         output logic [7:0] od, output logic [7:0] om, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    in_mode  = m;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~d;
    in_sel   = ~s;
    in_mode  = ~m;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    od = out_data;
    om = out_mask;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [2:0] s;
    logic [1:0] m;
    logic [7:0] ed;
    logic [7:0] em;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] od, om;
    int lat, w, hits;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_mode = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mask", out_mask, 0);
    rst_n = 1'b1;

    vecs[0] = '{8'hD2, 3'd1, 2'b00, 8'hA5, 8'hFF};
    vecs[1] = '{8'h2D, 3'd3, 2'b01, 8'hA5, 8'hFF};
    vecs[2] = '{8'hA5, 3'd0, 2'b00, 8'hA5, 8'hFF};
    vecs[3] = '{8'h05, 3'd5, 2'b10, 8'hA0, 8'hE0};
    vecs[4] = '{8'h80, 3'd7, 2'b11, 8'h01, 8'h01};
    vecs[5] = '{8'h3C, 3'd0, 2'b10, 8'h3C, 8'hFF};
    foreach (vecs[i]) begin
      run_job(vecs[i].d, vecs[i].s, vecs[i].m, od, om, lat);
      chk($sformatf("dir%0d_data", i), od, vecs[i].ed);
      chk($sformatf("dir%0d_mask", i), om, vecs[i].em);
      chk($sformatf("dir%0d_latency", i), lat, vecs[i].s + 1);
    end

    // Backpressure with in_valid held high carrying the next job.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hD2; in_sel = 3'd1; in_mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h2D; in_sel = 3'd3; in_mode = 2'b01;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'hA5);
      chk("bp_mask", out_mask, 8'hFF);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_valid", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_busy", in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_latency", lat, 4);
    chk("bp_second_data", out_data, 8'hA5);
    chk("bp_second_mask", out_mask, 8'hFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the third step of a six-step job.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h12; in_sel = 3'd6; in_mode = 2'b01;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_mask", out_mask, 0);
    hits = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    out_ready = 1'b0;
    chk("mid_rst_no_stale", hits, 0);

    // Loopback over every data value, shift amount and mode.
    for (int m = 0; m < 4; m++) begin
      for (int s = 0; s < 8; s++) begin
        for (int d = 0; d < 256; d++) begin
          run_job(fwd(8'(d), s, 2'(m)), 3'(s), 2'(m), od, om, lat);
          chk($sformatf("lb_m%0d_s%0d_d%0h_mask", m, s, d), om, exp_mask(s, 2'(m)));
          chk($sformatf("lb_m%0d_s%0d_d%0h_data", m, s, d), od, 8'(d) & exp_mask(s, 2'(m)));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
